data_mem_arbiter: RTL

Sequencing controller and two-port arbiter in front of the single-port `data_memory`. It shares the memory between the RISC-V core's load/store stage (port C) and the host/UART debug port (port H). A three-state run-phase FSM gates which port may access memory: host preload, core execution, then host read-back. The block generates the memory's `read_En`/`write_En`/`address`/`data_in`/`process_done` and returns read data to the issuing port.

---
 rtl/data_mem_arbiter_pkg.sv | 11 +
 rtl/data_mem_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default widths for the data memory arbiter and its sub-blocks.
package mem_ctrl_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ADDRESS_WIDTH_DEF = 30;
  localparam int CNT_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {LOAD, RUN, DONE} run_state_t;
  typedef enum logic {PORT_C, PORT_H} port_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is the core port, bit 1 the host port.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] req,
  input  logic [1:0] elig,
  output logic [1:0] gnt,
  output port_t      last_gnt
);

  port_t      last_q, last_d;
  logic [1:0] cand;

  always_comb begin
    cand   = req & elig;
    gnt    = 2'b00;
    last_d = last_q;
    // On a tie the port that did not win last time gets the grant.
    if (cand == 2'b11) begin
      gnt = (last_q == PORT_H) ? 2'b01 : 2'b10;
    end else begin
      gnt = cand;
    end
    if (gnt[0]) begin
      last_d = PORT_C;
    end else if (gnt[1]) begin
      last_d = PORT_H;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      last_q <= PORT_H;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_gnt = last_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Run-phase sequencer plus two-port arbiter sharing one single-port data memory
// between the core load/store stage (C) and the host debug port (H).
module data_mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     c_req,
  input  logic                     c_we,
  input  logic [ADDRESS_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0]    c_wdata,
  output logic                     c_gnt,
  output logic                     c_rvalid,
  input  logic                     h_req,
  input  logic                     h_we,
  input  logic [ADDRESS_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0]    h_wdata,
  output logic                     h_gnt,
  output logic                     h_rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  input  logic                     h_start,
  input  logic                     c_halt,
  input  logic                     h_restart,
  output logic                     core_run,
  output logic [CNT_WIDTH-1:0]     wait_cnt,
  output logic                     mem_read_En,
  output logic                     mem_write_En,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic                     mem_process_done,
  output run_state_t               dbg_state,
  output port_t                    dbg_last_gnt
);

  // Handshake: a port's request is accepted in any cycle where x_req && x_gnt;
  // x_gnt is combinational, and read data returns on x_rvalid exactly one cycle later.

  run_state_t           state_q, state_d;
  logic                 c_rvalid_q, c_rvalid_d;
  logic                 h_rvalid_q, h_rvalid_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]           elig, gnt;

  // Eligibility is forced off in reset so no memory enable can leak out.
  assign elig = rstN ? {1'b1, state_q == RUN} : 2'b00;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rstN     (rstN),
    .req      ({h_req, c_req}),
    .elig     (elig),
    .gnt      (gnt),
    .last_gnt (dbg_last_gnt)
  );

  assign c_gnt = gnt[0];
  assign h_gnt = gnt[1];

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      LOAD: if (h_start) state_d = RUN;
      RUN: begin
        if (c_halt) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
        if (c_req && !c_gnt && (wait_cnt_q != {CNT_WIDTH{1'b1}})) begin
          wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: if (h_restart) begin
        state_d    = LOAD;
        wait_cnt_d = '0;
      end
      default: state_d = LOAD;
    endcase
    c_rvalid_d = c_gnt && !c_we;
    h_rvalid_d = h_gnt && !h_we;
  end

  always_comb begin
    mem_read_En  = 1'b0;
    mem_write_En = 1'b0;
    mem_address  = '0;
    mem_data_in  = '0;
    if (c_gnt) begin
      mem_write_En = c_we;
      mem_read_En  = !c_we;
      mem_address  = c_addr;
      mem_data_in  = c_wdata;
    end else if (h_gnt) begin
      mem_write_En = h_we;
      mem_read_En  = !h_we;
      mem_address  = h_addr;
      mem_data_in  = h_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= LOAD;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      done_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
      done_q     <= done_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign c_rvalid         = c_rvalid_q;
  assign h_rvalid         = h_rvalid_q;
  assign rdata            = mem_data_out;
  assign mem_process_done = done_q;
  assign wait_cnt         = wait_cnt_q;
  assign core_run         = (state_q == RUN);
  assign dbg_state        = state_q;

endmodule
